// File: rtl/ef_pwm_guard_pkg.sv
// Shared defaults and output-select encoding for the PWM output guard.
package ef_pwm_guard_pkg;

  localparam int unsigned MPW_W_DEF = 8;
  localparam int unsigned FLT_W_DEF = 4;

  typedef enum logic [1:0] {
    SEL_PASS  = 2'd0,
    SEL_HOLD  = 2'd1,
    SEL_BLANK = 2'd2,
    SEL_SAFE  = 2'd3
  } out_sel_e;

endpackage

// File: rtl/ef_pwm_min_pulse.sv
// Per-channel output register with a minimum-pulse-width hold counter.
module ef_pwm_min_pulse
  import ef_pwm_guard_pkg::*;
#(
  parameter int unsigned MPW_W = MPW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             force_en,
  input  logic             force_val,
  input  logic             req,
  input  logic [MPW_W-1:0] min_pulse,
  output logic             out
);

  localparam logic [MPW_W-1:0] CNT_ONE = MPW_W'(1);

  logic             out_q, out_d;
  logic [MPW_W-1:0] cnt_q, cnt_d;
  out_sel_e         sel;

  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    sel   = SEL_PASS;
    if (clr) begin
      // disabled: drive the forced level and leave no hold pending
      sel   = SEL_SAFE;
      out_d = force_val;
      cnt_d = '0;
    end else if (force_en) begin
      sel   = SEL_SAFE;
      out_d = force_val;
      if (force_val != out_q) begin
        cnt_d = min_pulse;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (cnt_q != '0) begin
      sel   = SEL_HOLD;
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      out_d = req;
      if (req != out_q) begin
        cnt_d = min_pulse;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/ef_pwm_out_guard.sv
// PWM output guard: fault filter/latch, shoot-through blanking and min-pulse hold.
module ef_pwm_out_guard
  import ef_pwm_guard_pkg::*;
#(
  parameter int unsigned MPW_W = MPW_W_DEF,
  parameter int unsigned FLT_W = FLT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_a,
  input  logic             pwm_b,
  input  logic             fault_in,
  input  logic             flt_pol,
  input  logic [FLT_W-1:0] flt_filt,
  input  logic             clr_fault,
  input  logic [MPW_W-1:0] min_pulse,
  input  logic             safe_a,
  input  logic             safe_b,
  output logic             out_a,
  output logic             out_b,
  output logic             fault_latched,
  output logic             st_err
);

  localparam logic [FLT_W-1:0] FLT_ONE = FLT_W'(1);

  logic [1:0]       sync_q, sync_d;
  logic [FLT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             st_err_q, st_err_d;
  logic             flt_s, fault_set, cnt_hit;
  out_sel_e         sel;
  logic             force_en, force_a, force_b;

  always_comb begin
    sync_d  = {sync_q[0], fault_in};
    flt_s   = ~(sync_q[1] ^ flt_pol);
    cnt_hit = (cnt_q >= flt_filt);

    cnt_d = cnt_q;
    if (!en || !flt_s) begin
      cnt_d = '0;
    end else if (!cnt_hit) begin
      cnt_d = cnt_q + FLT_ONE;
    end

    // a set in the same cycle always beats a clear request
    fault_set = en & flt_s & cnt_hit;
    fault_d   = fault_set | (fault_q & ~(clr_fault & ~flt_s));

    if (!en || fault_d) begin
      sel = SEL_SAFE;
    end else if (pwm_a && pwm_b) begin
      sel = SEL_BLANK;
    end else begin
      sel = SEL_PASS;
    end

    st_err_d = (sel == SEL_BLANK);
    force_en = (sel == SEL_SAFE) || (sel == SEL_BLANK);
    force_a  = (sel == SEL_SAFE) ? safe_a : 1'b0;
    force_b  = (sel == SEL_SAFE) ? safe_b : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
      st_err_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
      st_err_q <= st_err_d;
    end
  end

  ef_pwm_min_pulse #(.MPW_W(MPW_W)) u_mp_a (
    .clk       (clk),
    .rst       (rst),
    .clr       (~en),
    .force_en  (force_en),
    .force_val (force_a),
    .req       (pwm_a),
    .min_pulse (min_pulse),
    .out       (out_a)
  );

  ef_pwm_min_pulse #(.MPW_W(MPW_W)) u_mp_b (
    .clk       (clk),
    .rst       (rst),
    .clr       (~en),
    .force_en  (force_en),
    .force_val (force_b),
    .req       (pwm_b),
    .min_pulse (min_pulse),
    .out       (out_b)
  );

  assign fault_latched = fault_q;
  assign st_err        = st_err_q;

endmodule

// File: tb/tb_ef_pwm_out_guard.sv
// Self-checking bench for ef_pwm_out_guard with a behavioural reference model.
module tb_ef_pwm_out_guard;

  logic       clk = 1'b0;
  logic       rst, en, pwm_a, pwm_b, fault_in, flt_pol, clr_fault, safe_a, safe_b;
  logic [3:0] flt_filt;
  logic [7:0] min_pulse;
  logic       out_a, out_b, fault_latched, st_err;

  ef_pwm_out_guard #(.MPW_W(8), .FLT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .pwm_a         (pwm_a),
    .pwm_b         (pwm_b),
    .fault_in      (fault_in),
    .flt_pol       (flt_pol),
    .flt_filt      (flt_filt),
    .clr_fault     (clr_fault),
    .min_pulse     (min_pulse),
    .safe_a        (safe_a),
    .safe_b        (safe_b),
    .out_a         (out_a),
    .out_b         (out_b),
    .fault_latched (fault_latched),
    .st_err        (st_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: ages count edges since an output last changed,
  // run counts consecutive qualified fault samples.
  localparam int BIG = 1 << 20;
  bit m_out_a, m_out_b, m_fault, m_st;
  int age_a, age_b, run;
  bit fq[$];

  function automatic void model_reset();
    m_out_a = 0; m_out_b = 0; m_fault = 0; m_st = 0;
    age_a = BIG; age_b = BIG; run = 0;
    fq = {1'b0, 1'b0};
  endfunction

  function automatic void chan_step(input bit forced, input bit fval, input bit req,
                                    input int m, inout bit cur, inout int age);
    bit nxt;
    if (forced) nxt = fval;
    else if (age >= m + 1) nxt = req;
    else nxt = cur;
    if (nxt != cur) age = 1;
    else if (age < BIG) age++;
    cur = nxt;
  endfunction

  function automatic void model_edge();
    bit raw, fs, set, nf;
    int m;
    m   = int'(min_pulse);
    raw = fq[fq.size() - 2];
    fq.push_back(fault_in);
    if (fq.size() > 8) void'(fq.pop_front());
    fs  = (raw == flt_pol);
    set = en && fs && (run >= int'(flt_filt));
    run = (en && fs) ? run + 1 : 0;
    nf  = set || (m_fault && !(clr_fault && !fs));
    m_fault = nf;
    m_st    = en && !nf && pwm_a && pwm_b;
    if (!en) begin
      m_out_a = safe_a; m_out_b = safe_b; age_a = BIG; age_b = BIG;
    end else if (nf) begin
      chan_step(1'b1, safe_a, pwm_a, m, m_out_a, age_a);
      chan_step(1'b1, safe_b, pwm_b, m, m_out_b, age_b);
    end else if (pwm_a && pwm_b) begin
      chan_step(1'b1, 1'b0, pwm_a, m, m_out_a, age_a);
      chan_step(1'b1, 1'b0, pwm_b, m, m_out_b, age_b);
    end else begin
      chan_step(1'b0, 1'b0, pwm_a, m, m_out_a, age_a);
      chan_step(1'b0, 1'b0, pwm_b, m, m_out_b, age_b);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pwm_a = 0; pwm_b = 0; fault_in = 0; flt_pol = 1;
    flt_filt = 4'd2; clr_fault = 0; min_pulse = 8'd0; safe_a = 0; safe_b = 0;
    #1;
    checks++;
    if ({out_a, out_b, fault_latched, st_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_state got=%b exp=0000", {out_a, out_b, fault_latched, st_err});
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
    checks++;
    if ({out_a, out_b, fault_latched, st_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_hold got=%b exp=0000", {out_a, out_b, fault_latched, st_err});
    end
  endtask

  task automatic test_pass_through();
    bit prev;
    min_pulse = 8'd0; pwm_b = 0;
    for (int i = 0; i < 40; i++) begin
      pwm_a = ((i / 5) % 2) == 1;
      prev  = pwm_a;
      step();
      checks++;
      if (out_a !== prev || st_err !== 1'b0) begin
        errors++; $display("FAIL pass_through i=%0d out_a=%b st_err=%b exp=%b/0", i, out_a, st_err, prev);
      end
      checks++;
      if ({out_a, out_b, fault_latched, st_err} !== {m_out_a, m_out_b, m_fault, m_st}) begin
        errors++; $display("FAIL pass_model i=%0d got=%b exp=%b", i,
                           {out_a, out_b, fault_latched, st_err}, {m_out_a, m_out_b, m_fault, m_st});
      end
    end
  endtask

  task automatic test_min_pulse();
    int cnt_hi;
    min_pulse = 8'd3; pwm_a = 0; pwm_b = 0;
    idle(6);
    pwm_a = 1; step(); pwm_a = 0;
    cnt_hi = out_a ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (out_a === 1'b1) cnt_hi++;
    end
    checks++;
    if (cnt_hi !== 4) begin
      errors++; $display("FAIL min_pulse_short high=%0d exp=4", cnt_hi);
    end
    idle(6);
    cnt_hi = 0;
    for (int i = 1; i <= 12; i++) begin
      pwm_a = (i <= 6);
      step();
      if (out_a === 1'b1) cnt_hi++;
      checks++;
      if (out_a !== (i <= 6)) begin
        errors++; $display("FAIL min_pulse_long edge=%0d out_a=%b exp=%b", i, out_a, (i <= 6));
      end
    end
    checks++;
    if (cnt_hi !== 6) begin
      errors++; $display("FAIL min_pulse_long_width high=%0d exp=6", cnt_hi);
    end
  endtask

  task automatic test_shoot_through();
    int st_cnt = 0;
    min_pulse = 8'd0; pwm_a = 1; pwm_b = 0;
    step();
    for (int i = 0; i < 2; i++) begin
      pwm_a = 1; pwm_b = 1;
      step();
      if (st_err === 1'b1) st_cnt++;
      checks++;
      if ({out_a, out_b, st_err} !== 3'b001) begin
        errors++; $display("FAIL shoot_blank i=%0d got=%b exp=001", i, {out_a, out_b, st_err});
      end
    end
    pwm_b = 0;
    step();
    if (st_err === 1'b1) st_cnt++;
    checks++;
    if ({out_a, out_b, st_err} !== 3'b100 || st_cnt != 2) begin
      errors++; $display("FAIL shoot_release got=%b st_cnt=%0d exp=100/2", {out_a, out_b, st_err}, st_cnt);
    end
    pwm_a = 0;
    step();
  endtask

  task automatic test_fault_filter();
    min_pulse = 8'd0; pwm_a = 0; pwm_b = 0; safe_a = 1; safe_b = 0;
    flt_pol = 1; flt_filt = 4'd2;
    for (int i = 0; i < 10; i++) begin
      fault_in = (i < 2);
      step();
      checks++;
      if (fault_latched !== 1'b0 || fault_latched !== m_fault) begin
        errors++; $display("FAIL fault_short i=%0d latched=%b exp=0", i, fault_latched);
      end
    end
    for (int e = 1; e <= 6; e++) begin
      fault_in = 1;
      step();
      checks++;
      if (fault_latched !== (e >= 5)) begin
        errors++; $display("FAIL fault_latency edge=%0d latched=%b exp=%b", e, fault_latched, (e >= 5));
      end
      if (e == 5) begin
        checks++;
        if ({out_a, out_b} !== 2'b10) begin
          errors++; $display("FAIL fault_safe got=%b exp=10", {out_a, out_b});
        end
      end
    end
  endtask

  task automatic test_fault_clear();
    clr_fault = 1; step(); clr_fault = 0;
    checks++;
    if (fault_latched !== 1'b1) begin
      errors++; $display("FAIL clr_while_active latched=%b exp=1", fault_latched);
    end
    fault_in = 0;
    idle(3);
    clr_fault = 1; step(); clr_fault = 0;
    checks++;
    if (fault_latched !== 1'b0 || {out_a, out_b} !== 2'b00) begin
      errors++; $display("FAIL clr_release latched=%b outs=%b exp=0/00", fault_latched, {out_a, out_b});
    end
    pwm_a = 1; step();
    checks++;
    if ({out_a, out_b, fault_latched} !== {m_out_a, m_out_b, m_fault} || out_a !== 1'b1) begin
      errors++; $display("FAIL clr_resume got=%b exp=100", {out_a, out_b, fault_latched});
    end
    pwm_a = 0; step();
  endtask

  task automatic test_enable();
    min_pulse = 8'd5; safe_a = 0; safe_b = 1; pwm_a = 0; pwm_b = 0;
    idle(8);
    pwm_a = 1; step();
    checks++;
    if (out_a !== 1'b1) begin
      errors++; $display("FAIL en_rise out_a=%b exp=1", out_a);
    end
    en = 0; step();
    checks++;
    if ({out_a, out_b} !== 2'b01) begin
      errors++; $display("FAIL en_safe got=%b exp=01", {out_a, out_b});
    end
    en = 1; step();
    checks++;
    if ({out_a, out_b} !== 2'b10) begin
      errors++; $display("FAIL en_hold_cleared got=%b exp=10", {out_a, out_b});
    end
    pwm_a = 0; step();
    checks++;
    if (out_a !== 1'b1 || out_a !== m_out_a) begin
      errors++; $display("FAIL en_hold_after out_a=%b exp=1", out_a);
    end
    idle(8);
  endtask

  task automatic test_reset_mid_fault();
    min_pulse = 8'd0; safe_a = 1; safe_b = 1; flt_pol = 1; flt_filt = 4'd0;
    pwm_a = 0; pwm_b = 0; fault_in = 1;
    idle(3);
    checks++;
    if (fault_latched !== 1'b1 || {out_a, out_b} !== 2'b11) begin
      errors++; $display("FAIL rst_prefault latched=%b outs=%b exp=1/11", fault_latched, {out_a, out_b});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_a, out_b, fault_latched, st_err} !== 4'b0000) begin
      errors++; $display("FAIL rst_async got=%b exp=0000", {out_a, out_b, fault_latched, st_err});
    end
    fault_in = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({out_a, out_b, fault_latched, st_err} !== {m_out_a, m_out_b, m_fault, m_st}) begin
        errors++; $display("FAIL rst_after i=%0d got=%b exp=%b", i,
                           {out_a, out_b, fault_latched, st_err}, {m_out_a, m_out_b, m_fault, m_st});
      end
    end
  endtask

  task automatic test_random();
    bit act;
    for (int seg = 0; seg < 8; seg++) begin
      en = 0; step();
      min_pulse = 8'($urandom_range(0, 6));
      flt_filt  = 4'($urandom_range(0, 4));
      flt_pol   = 1'($urandom_range(0, 1));
      safe_a    = 1'($urandom_range(0, 1));
      safe_b    = 1'($urandom_range(0, 1));
      act = 0;
      for (int i = 0; i < 250; i++) begin
        en = ($urandom_range(0, 49) != 0);
        if ($urandom_range(0, 3) == 0) pwm_a = ~pwm_a;
        if ($urandom_range(0, 3) == 0) pwm_b = ~pwm_b;
        if ($urandom_range(0, 19) == 0) act = ~act;
        fault_in  = flt_pol ? act : ~act;
        clr_fault = ($urandom_range(0, 9) == 0);
        step();
        checks++;
        if ({out_a, out_b, fault_latched, st_err} !== {m_out_a, m_out_b, m_fault, m_st}) begin
          errors++; $display("FAIL random seg=%0d i=%0d got=%b exp=%b", seg, i,
                             {out_a, out_b, fault_latched, st_err}, {m_out_a, m_out_b, m_fault, m_st});
        end
      end
    end
    clr_fault = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pass_through();
    test_min_pulse();
    test_shoot_through();
    test_fault_filter();
    test_fault_clear();
    test_enable();
    test_reset_mid_fault();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ef_pwm_out_guard.md
# ef_pwm_out_guard

Output-protection stage placed directly downstream of the timer's two PWM outputs (pwm0/pwm1), between the timer and the pads or gate driver. It forces safe pad levels on a filtered, latched external fault and blanks both outputs whenever the pair would shoot through. It also enforces a programmable minimum pulse width on each channel. All paths are synchronous to one clock, and the outputs are registered.

## Interface
- MPW_W, 8: width of the minimum-pulse-width setting and of the per-channel hold counters.
- FLT_W, 4: width of the fault-filter setting and of the filter counter.
- clk  in  1  block clock, same clock as the timer.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  guard enable; 0 drives safe levels.
- pwm_a  in  1  timer channel 0, already registered in clk domain.
- pwm_b  in  1  timer channel 1, already registered in clk domain.
- fault_in  in  1  raw external fault, asynchronous.
- flt_pol  in  1  fault polarity: 1 = active-high, 0 = active-low.
- flt_filt  in  FLT_W  number of extra consecutive samples required to qualify a fault.
- clr_fault  in  1  single-cycle request to clear the fault latch.
- min_pulse  in  MPW_W  M; minimum output level duration is M+1 cycles.
- safe_a  in  1  pad level for out_a in the safe state.
- safe_b  in  1  pad level for out_b in the safe state.
- out_a  out  1  guarded channel A.
- out_b  out  1  guarded channel B.
- fault_latched  out  1  sticky fault status.
- st_err  out  1  one-cycle pulse on each shoot-through detection.

## Operation
- Fault path: fault_in passes a 2-FF synchronizer, then is XNORed with flt_pol to give flt_s.
- Filter counter increments while flt_s=1 and clears to 0 when flt_s=0.
- The latch sets on the edge where flt_s=1 and cnt==flt_filt. The counter saturates there.
- clr_fault clears the latch only if flt_s=0 that cycle. If flt_s=1, or the latch is setting in the same cycle, set wins.
- Output priority, highest first: rst > en=0 > fault > shoot-through > min-pulse hold > pass-through.
- en=0: out_a/out_b = safe_a/safe_b. Hold counters and filter counter clear; the fault latch is kept.
- Fault: the output registers load safe_a/safe_b on the same edge fault_latched sets.
- Shoot-through: pwm_a=1 and pwm_b=1 in the same cycle forces both outputs to 0 and pulses st_err. This bypasses the hold.
- Min-pulse hold, per channel: when the output register changes value, the hold counter loads M. While the counter is nonzero it decrements each cycle and the output holds.
  - At counter 0, the output follows the current request; a request pending at expiry is applied then.
  - A forced change (safe or blank) also reloads the counter.
  - M=0 means no restriction.

## Timing
- Reset values: out_a=0, out_b=0, fault_latched=0, st_err=0, all counters 0.
- Pass-through latency: 1 clk from pwm_a/pwm_b to out_a/out_b.
- Fault latency, with edge 1 being the first edge sampling fault_in active: fault_latched and safe outputs appear at edge 3+flt_filt.
- A fault pulse shorter than flt_filt+1 synchronized samples never latches.
- st_err is registered: it is high for the cycle after each overlapping input cycle.
- Reset asserted mid-pulse or mid-fault returns everything to reset values immediately, asynchronously.

## Structure
- Shared package ef_pwm_guard_pkg holds MPW_W/FLT_W defaults and the output-select encoding SEL_PASS, SEL_HOLD, SEL_BLANK, SEL_SAFE.
- Sub-module ef_pwm_min_pulse is instantiated twice, once per channel. It contains the hold counter and output register, with inputs req, force, force_val and min_pulse.
- The top holds the synchronizer, filter counter, fault latch, shoot-through detect and select logic.

## Test plan
- **Pass-through:** en=1, M=0, pwm_a toggles every 5 clk → out_a identical, delayed 1 clk; st_err=0.
- **Min pulse:** M=3, pwm_a high for 1 clk → out_a high exactly 4 clk. pwm_a high for 6 clk → out_a high 6 clk, delayed 1 clk.
- **Shoot-through:** pwm_a=pwm_b=1 for 2 clk → out_a=out_b=0 during those 2 cycles (+1 latency); st_err high 2 cycles.
- **Fault filter:** flt_pol=1, flt_filt=2.
  - fault_in high 2 clk → no latch.
  - fault_in high 5 clk → fault_latched at edge 5; outputs = safe_a=1, safe_b=0.
- **Fault clear:** clr_fault while fault_in still high → latch stays. Drop fault_in, wait 3 clk, clr_fault → fault_latched=0 next edge, pass-through resumes.
- **Enable/reset:** en=0 mid-pulse → safe levels next edge, hold counter cleared. rst pulse while fault latched → all outputs 0 immediately.
